// File: rtl/vga_timing_gen.sv
// Raster timing generator: four sub-cycles per pixel, pixel/line counters, and registered
// active/sync/frame flags. Each flag is derived from the next-cycle counters so that it lines up with them.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] pixel_state,
   output logic [9:0] pixel_counter,
   output logic [9:0] line_counter,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] C_H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] C_V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] C_H_ACTIVE   = 10'(H_ACTIVE);
   localparam logic [9:0] C_V_ACTIVE   = 10'(V_ACTIVE);
   localparam logic [9:0] C_HS_START   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] C_HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] C_VS_START   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] C_VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [1:0] r_pixelState;
   logic [9:0] r_pixelCounter;
   logic [9:0] r_lineCounter;
   logic       r_active;
   logic       r_hsync;
   logic       r_vsync;
   logic       r_frameStart;

   logic [1:0] w_stateNext;
   logic [9:0] w_pixelNext;
   logic [9:0] w_lineNext;
   logic       w_frameWrap;
   logic       w_activeNext;
   logic       w_hsyncNext;
   logic       w_vsyncNext;

   always_comb begin
      w_stateNext = r_pixelState + 2'd1;
      w_pixelNext = r_pixelCounter;
      w_lineNext  = r_lineCounter;
      w_frameWrap = 1'b0;
      if (r_pixelState == 2'd3) begin
         if (r_pixelCounter == C_H_LAST) begin
            w_pixelNext = '0;
            if (r_lineCounter == C_V_LAST) begin
               w_lineNext  = '0;
               w_frameWrap = 1'b1;
            end else begin
               w_lineNext = r_lineCounter + 10'd1;
            end
         end else begin
            w_pixelNext = r_pixelCounter + 10'd1;
         end
      end
      w_activeNext = (w_pixelNext < C_H_ACTIVE) && (w_lineNext < C_V_ACTIVE);
      w_hsyncNext  = !((w_pixelNext >= C_HS_START) && (w_pixelNext <= C_HS_END));
      w_vsyncNext  = !((w_lineNext >= C_VS_START) && (w_lineNext <= C_VS_END));
   end

   // Reset lands on the visible origin, so active is high while syncs stay idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pixelState   <= '0;
         r_pixelCounter <= '0;
         r_lineCounter  <= '0;
         r_active       <= 1'b1;
         r_hsync        <= 1'b1;
         r_vsync        <= 1'b1;
         r_frameStart   <= 1'b0;
      end else begin
         r_pixelState   <= w_stateNext;
         r_pixelCounter <= w_pixelNext;
         r_lineCounter  <= w_lineNext;
         r_active       <= w_activeNext;
         r_hsync        <= w_hsyncNext;
         r_vsync        <= w_vsyncNext;
         r_frameStart   <= w_frameWrap;
      end
   end

   assign pixel_state   = r_pixelState;
   assign pixel_counter = r_pixelCounter;
   assign line_counter  = r_lineCounter;
   assign active        = r_active;
   assign hsync         = r_hsync;
   assign vsync         = r_vsync;
   assign frame_start   = r_frameStart;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for the horizontal timing and a reduced-geometry
// instance so that whole frames fit in a short run. Both are compared against an elapsed-clock model.
module tb_vga_timing_gen;

   logic clk;
   logic rst_n;

   logic [1:0] stA, stB;
   logic [9:0] pxA, pxB, lnA, lnB;
   logic       actA, actB, hsA, hsB, vsA, vsB, fsA, fsB;

   int checks = 0;
   int errors = 0;
   int n      = 0;
   int hsLowCount = 0;
   int vsLowCount = 0;
   bit phaseOne   = 1'b1;
   int fsTimes[$];

   // Reduced geometry: 31 pixels x 17 lines, so a frame lasts 2108 clocks.
   localparam int B_HA = 16, B_HF = 4, B_HS = 6, B_HB = 5;
   localparam int B_VA = 10, B_VF = 2, B_VS = 2, B_VB = 3;
   localparam int B_FRAME = 4 * (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

   typedef struct {
      int st;
      int px;
      int ln;
      bit act;
      bit hs;
      bit vs;
      bit fs;
   } exp_t;

   typedef struct {
      int   cyc;
      exp_t e;
   } vec_t;

   vga_timing_gen dutA (
      .clk(clk), .rst_n(rst_n), .pixel_state(stA), .pixel_counter(pxA), .line_counter(lnA),
      .active(actA), .hsync(hsA), .vsync(vsA), .frame_start(fsA)
   );

   vga_timing_gen #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
   ) dutB (
      .clk(clk), .rst_n(rst_n), .pixel_state(stB), .pixel_counter(pxB), .line_counter(lnB),
      .active(actB), .hsync(hsB), .vsync(vsB), .frame_start(fsB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs after c clocks since reset release, straight from the raster arithmetic.
   function automatic exp_t model(int c, int ha, int hf, int hsy, int hb,
                                  int va, int vf, int vsy, int vb);
      exp_t m;
      int ht, vt, pix;
      ht    = ha + hf + hsy + hb;
      vt    = va + vf + vsy + vb;
      pix   = c / 4;
      m.st  = c % 4;
      m.px  = pix % ht;
      m.ln  = (pix / ht) % vt;
      m.act = (m.px < ha) && (m.ln < va);
      m.hs  = !((m.px >= ha + hf) && (m.px < ha + hf + hsy));
      m.vs  = !((m.ln >= va + vf) && (m.ln < va + vf + vsy));
      m.fs  = (c > 0) && (c % (4 * ht * vt) == 0);
      return m;
   endfunction

   function automatic logic [25:0] packExp(exp_t e);
      return {e.st[1:0], e.px[9:0], e.ln[9:0], e.act, e.hs, e.vs, e.fs};
   endfunction

   task automatic checkOutput(input string name, input logic [25:0] got, input logic [25:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s at clock %0d: got st=%0d px=%0d ln=%0d act/hs/vs/fs=%b, expected st=%0d px=%0d ln=%0d act/hs/vs/fs=%b",
                  name, n, got[25:24], got[23:14], got[13:4], got[3:0],
                  want[25:24], want[23:14], want[13:4], want[3:0]);
      end
   endtask

   task automatic checkCount(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic checkBoth(input string tag);
      checkOutput({tag, "_full"}, {stA, pxA, lnA, actA, hsA, vsA, fsA},
                  packExp(model(n, 640, 16, 96, 48, 480, 10, 2, 33)));
      checkOutput({tag, "_small"}, {stB, pxB, lnB, actB, hsB, vsB, fsB},
                  packExp(model(n, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB)));
   endtask

   // Advance one clock and compare both instances half a period later.
   task automatic applyStimulus();
      @(posedge clk);
      n++;
      @(negedge clk);
      checkBoth("model");
      if (phaseOne) begin
         if (n >= 3200 && n < 6400 && !hsA) hsLowCount++;
         if (n >= B_FRAME && n < 2 * B_FRAME && !vsB) vsLowCount++;
         if (fsB) fsTimes.push_back(n);
      end
   endtask

   task automatic pulseReset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n = 0;
      checkBoth("async_reset");
      @(negedge clk);
      @(negedge clk);
      checkBoth("reset_hold");
      rst_n = 1'b1;
      n = 0;
   endtask

   vec_t vecs[14];
   exp_t resetVal;

   initial begin
      vecs[0]  = '{0,    '{0, 0,   0, 1, 1, 1, 0}};
      vecs[1]  = '{1,    '{1, 0,   0, 1, 1, 1, 0}};
      vecs[2]  = '{3,    '{3, 0,   0, 1, 1, 1, 0}};
      vecs[3]  = '{4,    '{0, 1,   0, 1, 1, 1, 0}};
      vecs[4]  = '{12,   '{0, 3,   0, 1, 1, 1, 0}};
      vecs[5]  = '{2559, '{3, 639, 0, 1, 1, 1, 0}};
      vecs[6]  = '{2560, '{0, 640, 0, 0, 1, 1, 0}};
      vecs[7]  = '{2623, '{3, 655, 0, 0, 1, 1, 0}};
      vecs[8]  = '{2624, '{0, 656, 0, 0, 0, 1, 0}};
      vecs[9]  = '{3007, '{3, 751, 0, 0, 0, 1, 0}};
      vecs[10] = '{3008, '{0, 752, 0, 0, 1, 1, 0}};
      vecs[11] = '{3199, '{3, 799, 0, 0, 1, 1, 0}};
      vecs[12] = '{3200, '{0, 0,   1, 1, 1, 1, 0}};
      vecs[13] = '{3204, '{0, 1,   1, 1, 1, 1, 0}};
      resetVal = '{0, 0, 0, 1, 1, 1, 0};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_full", {stA, pxA, lnA, actA, hsA, vsA, fsA}, packExp(resetVal));
      checkOutput("reset_small", {stB, pxB, lnB, actB, hsB, vsB, fsB}, packExp(resetVal));
      rst_n = 1'b1;
      n = 0;

      for (int i = 0; i < 14; i++) begin
         while (n < vecs[i].cyc) applyStimulus();
         checkOutput($sformatf("table%0d", i), {stA, pxA, lnA, actA, hsA, vsA, fsA},
                     packExp(vecs[i].e));
      end

      while (n < 4 * B_FRAME + 100) applyStimulus();
      checkCount("hsync_low_clocks", hsLowCount, 4 * 96);
      checkCount("vsync_low_clocks", vsLowCount, 4 * B_VS * (B_HA + B_HF + B_HS + B_HB));
      checkCount("frame_pulse_count", fsTimes.size(), 4);
      if (fsTimes.size() >= 1) checkCount("first_frame_pulse", fsTimes[0], B_FRAME);
      for (int i = 1; i < fsTimes.size(); i++)
         checkCount("frame_pulse_spacing", fsTimes[i] - fsTimes[i-1], B_FRAME);
      phaseOne = 1'b0;

      // Random mid-raster resets, including inside sync and blanking.
      for (int k = 0; k < 6; k++) begin
         int runLen;
         runLen = int'($urandom_range(1, 3 * B_FRAME));
         pulseReset();
         repeat (runLen) applyStimulus();
      end

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
